// File: rtl/hsi_mse_streamer_pkg.sv
// hsi_mse_streamer_pkg: shared sizes and FSM state for the MSE element streamer.
package hsi_mse_streamer_pkg;
    localparam int WORD_WIDTH = 32;
    localparam int DATA_WIDTH = 16;
    localparam int DATA_PER_WORD = WORD_WIDTH / DATA_WIDTH;
    localparam int HSI_BANDS = 128;
    localparam int ELEMENTS = HSI_BANDS / DATA_PER_WORD;
    localparam int CNT_WIDTH = $clog2(ELEMENTS);
    localparam int ADDR_WIDTH = 16;
    localparam int MSE_TIMEOUT = 64;
    localparam int TO_WIDTH = $clog2(MSE_TIMEOUT);
    typedef enum logic [2:0] {IDLE, REQ, DRAIN, WAIT_MSE, RESULT} state_t;
endpackage

// File: rtl/hsi_mse_addr_gen.sv
// hsi_mse_addr_gen: word counter and wrapping base+k read addresses for both vectors.
module hsi_mse_addr_gen
    import hsi_mse_streamer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  adv,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  first,
    output logic                  last
);
    logic [ADDR_WIDTH-1:0] base_a_q;
    logic [ADDR_WIDTH-1:0] base_b_q;
    logic [CNT_WIDTH-1:0]  k;
    always_ff @(posedge clk) begin
        if (rst) begin
            base_a_q <= '0;
            base_b_q <= '0;
            k <= '0;
        end else if (load) begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            k <= '0;
        end else if (adv) begin
            k <= k + 1'b1;
        end
    end
    assign addr_a = base_a_q + ADDR_WIDTH'(k);
    assign addr_b = base_b_q + ADDR_WIDTH'(k);
    assign first = k == '0;
    assign last = k == CNT_WIDTH'(ELEMENTS - 1);
endmodule

// File: rtl/hsi_mse_streamer.sv
// hsi_mse_streamer: streams two SRAM vectors into hsi_mse and returns the MSE (timeout via HSI_MSE_STREAMER_TIMEOUT_EN).
module hsi_mse_streamer
    import hsi_mse_streamer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    input  logic [WORD_WIDTH-1:0] mem_rdata_a,
    input  logic [WORD_WIDTH-1:0] mem_rdata_b,
    output logic                  start_vctr,
    output logic [WORD_WIDTH-1:0] element_a,
    output logic [WORD_WIDTH-1:0] element_b,
    output logic                  element_valid,
    input  logic [WORD_WIDTH-1:0] mse,
    input  logic                  mse_valid,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [WORD_WIDTH-1:0] result_mse,
    output logic                  result_err,
    output logic                  busy
);
    state_t state;
    logic   load;
    logic   grant;
    logic   first;
    logic   last;
    logic   rd_valid;
    logic   rd_first;
    assign load = state == IDLE && cmd_valid;
    assign grant = state == REQ && mem_gnt;
    assign cmd_ready = state == IDLE;
    assign mem_req = state == REQ;
    assign busy = state != IDLE;

    hsi_mse_addr_gen u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .adv    (grant),
        .base_a (cmd_addr_a),
        .base_b (cmd_addr_b),
        .addr_a (mem_addr_a),
        .addr_b (mem_addr_b),
        .first  (first),
        .last   (last)
    );

`ifdef HSI_MSE_STREAMER_TIMEOUT_EN
    logic [TO_WIDTH-1:0] to_cnt;
    logic                expired;
    assign expired = to_cnt == TO_WIDTH'(MSE_TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst || state != WAIT_MSE) to_cnt <= '0;
        else to_cnt <= to_cnt + 1'b1;
        if (rst) result_err <= 1'b0;
        else if (state == WAIT_MSE) result_err <= !mse_valid && expired;
    end
`else
    assign result_err = 1'b0;
`endif

    // rd_* track the one-cycle SRAM latency so each word lands two cycles after its grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            element_valid <= 1'b0;
            start_vctr <= 1'b0;
            element_a <= '0;
            element_b <= '0;
            result_valid <= 1'b0;
            result_mse <= '0;
        end else begin
            rd_valid <= grant;
            rd_first <= grant && first;
            element_valid <= rd_valid;
            start_vctr <= rd_first;
            if (rd_valid) begin
                element_a <= mem_rdata_a;
                element_b <= mem_rdata_b;
            end
            case (state)
                IDLE: if (cmd_valid) state <= REQ;
                REQ: if (grant && last) state <= DRAIN;
                DRAIN: state <= WAIT_MSE;
                WAIT_MSE: begin
                    if (mse_valid) begin
                        state <= RESULT;
                        result_valid <= 1'b1;
                        result_mse <= mse;
                    end
`ifdef HSI_MSE_STREAMER_TIMEOUT_EN
                    else if (expired) begin
                        state <= RESULT;
                        result_valid <= 1'b1;
                        result_mse <= '1;
                    end
`endif
                end
                RESULT: if (result_ready) begin
                    state <= IDLE;
                    result_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hsi_mse_streamer.sv
// tb_hsi_mse_streamer: randomized SRAM/grant/hsi_mse environment with a scoreboard for hsi_mse_streamer.
module tb_hsi_mse_streamer;
    import hsi_mse_streamer_pkg::*;
    logic                  clk = 0;
    logic                  rst = 1;
    logic                  cmd_valid = 0;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr_a = 0;
    logic [ADDR_WIDTH-1:0] cmd_addr_b = 0;
    logic                  mem_req;
    logic                  mem_gnt = 0;
    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic [ADDR_WIDTH-1:0] mem_addr_b;
    logic [WORD_WIDTH-1:0] mem_rdata_a = 0;
    logic [WORD_WIDTH-1:0] mem_rdata_b = 0;
    logic                  start_vctr;
    logic [WORD_WIDTH-1:0] element_a;
    logic [WORD_WIDTH-1:0] element_b;
    logic                  element_valid;
    logic [WORD_WIDTH-1:0] mse = 0;
    logic                  mse_valid = 0;
    logic                  result_valid;
    logic                  result_ready = 0;
    logic [WORD_WIDTH-1:0] result_mse;
    logic                  result_err;
    logic                  busy;

    always #5 clk = ~clk;

    hsi_mse_streamer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr_a    (cmd_addr_a),
        .cmd_addr_b    (cmd_addr_b),
        .mem_req       (mem_req),
        .mem_gnt       (mem_gnt),
        .mem_addr_a    (mem_addr_a),
        .mem_addr_b    (mem_addr_b),
        .mem_rdata_a   (mem_rdata_a),
        .mem_rdata_b   (mem_rdata_b),
        .start_vctr    (start_vctr),
        .element_a     (element_a),
        .element_b     (element_b),
        .element_valid (element_valid),
        .mse           (mse),
        .mse_valid     (mse_valid),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_mse    (result_mse),
        .result_err    (result_err),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_errs = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] mem_a [65536];
    logic [31:0] mem_b [65536];

    function automatic longint sqd(input logic [31:0] a, input logic [31:0] b);
        longint s;
        longint d;
        s = 0;
        for (int i = 0; i < DATA_PER_WORD; i++) begin
            d = longint'(a[i*DATA_WIDTH +: DATA_WIDTH]) - longint'(b[i*DATA_WIDTH +: DATA_WIDTH]);
            s += d * d;
        end
        return s;
    endfunction

    function automatic logic [31:0] ref_mse(input logic [15:0] ba, input logic [15:0] bb);
        longint s;
        s = 0;
        for (int k = 0; k < ELEMENTS; k++) s += sqd(mem_a[16'(ba + k)], mem_b[16'(bb + k)]);
        return 32'(s / HSI_BANDS);
    endfunction

    logic [15:0] eba = 0;
    logic [15:0] ebb = 0;
    logic [15:0] pa_a = 0;
    logic [15:0] pa_b = 0;
    int     ek = 0;
    int     gk = 0;
    int     gnt_pct = 100;
    int     emu_n = 0;
    int     emu_dly = 0;
    int     cyc = 0;
    int     t_wait = 0;
    longint emu_sum = 0;
    bit     gh1 = 0;
    bit     gh2 = 0;
    bit     pg = 0;
    bit     suppress = 0;
    bit     junk_en = 0;

    // SRAM, arbiter and hsi_mse stand-ins plus the stream scoreboard, all at the falling edge
    always @(negedge clk) begin
        bit g;
        cyc++;
        if (cmd_valid && cmd_ready && !rst) begin
            eba = cmd_addr_a;
            ebb = cmd_addr_b;
            ek = 0;
            gk = 0;
            emu_n = 0;
        end
        chk("elem_valid", element_valid, gh2);
        if (element_valid) begin
            chk("elem_a", element_a, mem_a[16'(eba + ek)]);
            chk("elem_b", element_b, mem_b[16'(ebb + ek)]);
            chk("start", start_vctr, ek == 0);
            if (start_vctr) begin
                emu_sum = 0;
                emu_n = 0;
            end
            emu_sum += sqd(element_a, element_b);
            emu_n++;
            if (ek == ELEMENTS - 1) t_wait = cyc;
            ek++;
            if (emu_n == ELEMENTS) emu_dly = $urandom_range(1, 6);
        end else begin
            chk("start_idle", start_vctr, 0);
        end
        mse_valid = 0;
        mse = $urandom;
        if (emu_dly > 0) begin
            emu_dly--;
            if (emu_dly == 0 && !suppress) begin
                mse_valid = 1;
                mse = 32'(emu_sum / HSI_BANDS);
            end
        end else if (junk_en && emu_n < ELEMENTS - 4 && $urandom_range(7) == 0) begin
            mse_valid = 1;
        end
        mem_rdata_a = pg ? mem_a[pa_a] : $urandom;
        mem_rdata_b = pg ? mem_b[pa_b] : $urandom;
        mem_gnt = $urandom_range(99) < gnt_pct;
        g = mem_req && mem_gnt;
        if (g) begin
            chk("addr_a", mem_addr_a, 16'(eba + gk));
            chk("addr_b", mem_addr_b, 16'(ebb + gk));
            gk++;
        end
        gh2 = gh1;
        gh1 = g;
        pg = g;
        pa_a = mem_addr_a;
        pa_b = mem_addr_b;
        if (rst) begin
            gh1 = 0;
            gh2 = 0;
            pg = 0;
            emu_dly = 0;
            emu_n = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        tick();
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr_a"}, mem_addr_a, 0);
        chk({tag, "_elem_valid"}, element_valid, 0);
        chk({tag, "_start"}, start_vctr, 0);
        chk({tag, "_elem_a"}, element_a, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result_mse"}, result_mse, 0);
        chk({tag, "_result_err"}, result_err, 0);
    endtask

    task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_mse,
                           input bit exp_err, input int hold);
        int i;
        @(posedge clk);
        #1;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_valid = 1;
        @(posedge clk);
        #1;
        cmd_valid = 0;
        cmd_addr_a = $urandom;
        cmd_addr_b = $urandom;
        for (i = 0; i < 5000 && !result_valid; i++) tick();
        chk("result_wait", result_valid, 1);
        chk("elem_count", ek, ELEMENTS);
        chk("result_mse", result_mse, exp_mse);
        chk("result_err", result_err, exp_err);
        if (exp_err) chk("timeout_lat", cyc - t_wait, MSE_TIMEOUT);
        for (i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", result_valid, 1);
            chk("hold_mse", result_mse, exp_mse);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk);
        #1;
        result_ready = 1;
        @(posedge clk);
        #1;
        result_ready = 0;
        tick();
        chk("accept_cmd_ready", cmd_ready, 1);
        chk("accept_result_valid", result_valid, 0);
        chk("accept_busy", busy, 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        for (int i = 0; i < 65536; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_reset("rst");
        junk_en = 1;
        result_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_result_valid", result_valid, 0);
        end
        result_ready = 0;
        junk_en = 0;
        for (int k = 0; k < ELEMENTS; k++) begin
            mem_a[16'h0100 + k] = 32'h0004_0002;
            mem_b[16'h0200 + k] = 32'h0;
        end
        gnt_pct = 100;
        run_cmd(16'h0100, 16'h0200, 32'h0000_000A, 0, 0);
        gnt_pct = 50;
        junk_en = 1;
        run_cmd(16'h0100, 16'h0200, 32'h0000_000A, 0, 0);
        gnt_pct = 70;
        run_cmd(16'hFFFE, 16'h7000, ref_mse(16'hFFFE, 16'h7000), 0, 0);
        ra = $urandom;
        rb = $urandom;
        run_cmd(ra, rb, ref_mse(ra, rb), 0, 10);
        gnt_pct = 100;
        @(posedge clk);
        #1;
        cmd_addr_a = 16'h3000;
        cmd_addr_b = 16'h4000;
        cmd_valid = 1;
        @(posedge clk);
        #1;
        cmd_valid = 0;
        for (int i = 0; i < 500 && ek < 20; i++) tick();
        chk("mid_reach_k20", ek >= 20, 1);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check_reset("midrst");
        gnt_pct = 60;
        ra = $urandom;
        rb = $urandom;
        run_cmd(ra, rb, ref_mse(ra, rb), 0, 0);
`ifdef HSI_MSE_STREAMER_TIMEOUT_EN
        junk_en = 0;
        suppress = 1;
        gnt_pct = 100;
        run_cmd(16'h0100, 16'h0200, 32'hFFFF_FFFF, 1, 0);
        suppress = 0;
        run_cmd(16'h0100, 16'h0200, 32'h0000_000A, 0, 0);
`endif
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
